// File: rtl/coding_word_queue.sv
// coding_word_queue: serial-to-parallel bit packer feeding a word FIFO.
// Coded bits arrive one per wrreq strobe and are packed into a WORD_W-bit
// word; completed (or flushed, zero-padded) words are queued in a DEPTH-entry
// FIFO and popped into a registered q with a one-cycle q_valid pulse.
module coding_word_queue #(
    parameter int WORD_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_input,
    input  logic                       wrreq,
    input  logic                       flush,
    input  logic                       rdreq,
    output logic [WORD_W-1:0]          q,
    output logic                       q_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     usedw,
    output logic [$clog2(WORD_W)-1:0]  bit_cnt,
    output logic                       overflow
);

    localparam int CW = $clog2(WORD_W);
    localparam int PW = $clog2(DEPTH);
    localparam int UW = PW + 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [UW-1:0] FULL_CNT = UW'(DEPTH);
    localparam logic [UW-1:0] ONE_CNT  = UW'(1);

    // Packing register and the bit position the next strobe lands in
    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] bit_mask;
    logic [WORD_W-1:0] pack_next;
    logic [CW-1:0]     bit_pos;

    // Word storage; pointers wrap naturally at DEPTH (power of two)
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Per-edge control decisions
    logic              word_done;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [UW-1:0]     usedw_next;

    // Bit placement: first received bit goes to bit 0, or to the MSB when
    // MSB_FIRST is set. The incoming bit is merged combinationally so a
    // word completed (or flushed) on this edge already contains it.
    always_comb begin
        bit_pos = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt) : bit_cnt;
        bit_mask = '0;
        bit_mask[bit_pos] = 1'b1;
        pack_next = pack_reg;
        if (wrreq && bit_input) begin
            pack_next = pack_reg | bit_mask;
        end
    end

    // Push/pop decisions. flush together with wrreq yields a single push of
    // the word including the current bit, even when that bit completes it.
    // A push into a full FIFO only succeeds if a pop frees a slot that edge.
    always_comb begin
        word_done = wrreq && (bit_cnt == LAST_BIT);
        push      = word_done || (flush && (wrreq || (bit_cnt != '0)));
        pop       = rdreq && !empty;
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        case ({push_ok, pop})
            2'b10:   usedw_next = usedw + ONE_CNT;
            2'b01:   usedw_next = usedw - ONE_CNT;
            default: usedw_next = usedw;
        endcase
    end

    // Packing register and bit counter; both clear after every push,
    // including a push that gets dropped on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_reg <= '0;
            bit_cnt  <= '0;
        end else if (push) begin
            pack_reg <= '0;
            bit_cnt  <= '0;
        end else if (wrreq) begin
            pack_reg <= pack_next;
            bit_cnt  <= bit_cnt + CW'(1);
        end
    end

    // Word storage write; no reset needed since usedw gates every read
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= pack_next;
        end
    end

    // Pointers and occupancy flags, all registered from the same next count
    // so empty/full/usedw always agree within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            usedw <= usedw_next;
            empty <= (usedw_next == '0);
            full  <= (usedw_next == FULL_CNT);
        end
    end

    // Read port: q loads the oldest word on a pop and holds otherwise.
    // On a simultaneous push/pop while full, both pointers address the same
    // slot; the read sees the old word because the write lands at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= pop;
            if (pop) begin
                q <= mem[rd_ptr];
            end
        end
    end

    // Sticky overflow: set on a dropped word, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coding_word_queue.sv
// Bench for coding_word_queue: two instances (LSB-first and MSB-first packing)
// share stimulus; expected pop data is queued per instance and a monitor
// compares it whenever q_valid is seen.
module tb_coding_word_queue;

    logic       clk;
    logic       rst;
    logic       bit_input;
    logic       wrreq;
    logic       flush;
    logic       rdreq;

    logic [7:0] q0, q1;
    logic       q_valid0, q_valid1;
    logic       empty0, empty1;
    logic       full0, full1;
    logic [2:0] usedw0, usedw1;
    logic [2:0] bit_cnt0, bit_cnt1;
    logic       overflow0, overflow1;

    int checks;
    int failures;

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic [7:0] e0, e1;

    coding_word_queue #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .bit_input(bit_input), .wrreq(wrreq),
        .flush(flush), .rdreq(rdreq), .q(q0), .q_valid(q_valid0),
        .empty(empty0), .full(full0), .usedw(usedw0), .bit_cnt(bit_cnt0),
        .overflow(overflow0)
    );

    coding_word_queue #(.WORD_W(8), .DEPTH(4), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .bit_input(bit_input), .wrreq(wrreq),
        .flush(flush), .rdreq(rdreq), .q(q1), .q_valid(q_valid1),
        .empty(empty1), .full(full1), .usedw(usedw1), .bit_cnt(bit_cnt1),
        .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; returns at the following negedge
    task automatic step(input logic w, input logic b, input logic f, input logic r);
        wrreq = w; bit_input = b; flush = f; rdreq = r;
        @(negedge clk);
        wrreq = 1'b0; bit_input = 1'b0; flush = 1'b0; rdreq = 1'b0;
    endtask

    // Serialise a byte, bit 0 first (byte values used are bit palindromes,
    // so both packing orders store the same word)
    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) step(1'b1, v[i], 1'b0, 1'b0);
    endtask

    task automatic do_pop(input logic [7:0] v0, input logic [7:0] v1);
        exp0.push_back(v0);
        exp1.push_back(v1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Monitor: every q_valid pulse must match the oldest expected word
    always @(posedge clk) begin
        #1;
        if (q_valid0 === 1'b1) begin
            checks++;
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL mon0_unexpected_pop actual=0x%0h expected=none", q0);
            end else begin
                e0 = exp0.pop_front();
                if (q0 !== e0) begin
                    failures++;
                    $display("FAIL mon0_q actual=0x%0h expected=0x%0h", q0, e0);
                end
            end
        end
        if (q_valid1 === 1'b1) begin
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL mon1_unexpected_pop actual=0x%0h expected=none", q1);
            end else begin
                e1 = exp1.pop_front();
                if (q1 !== e1) begin
                    failures++;
                    $display("FAIL mon1_q actual=0x%0h expected=0x%0h", q1, e1);
                end
            end
        end
    end

    initial begin
        logic [15:0] s;
        checks = 0; failures = 0;
        rst = 1'b1; wrreq = 1'b0; bit_input = 1'b0; flush = 1'b0; rdreq = 1'b0;
        @(negedge clk);
        // Reset asserted together with a write strobe: reset wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        chk("rst_q", q0, 8'h00);
        chk("rst_q_valid", q_valid0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_usedw", usedw0, 0);
        chk("rst_bit_cnt", bit_cnt0, 0);
        chk("rst_overflow", overflow0, 0);

        // 16-bit stream, first bit leftmost
        s = 16'b0011110000001111;
        for (int i = 15; i >= 0; i--) step(1'b1, s[i], 1'b0, 1'b0);
        chk("stream_usedw", usedw0, 2);
        chk("stream_bit_cnt", bit_cnt0, 0);
        do_pop(8'h3C, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        do_pop(8'hF0, 8'h0F);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stream_q_hold0", q0, 8'hF0);
        chk("stream_q_hold1", q1, 8'h0F);
        chk("stream_q_valid_low", q_valid0, 0);
        chk("stream_empty", empty0, 1);

        // Partial word then flush
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("partial_bit_cnt", bit_cnt0, 3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_usedw", usedw0, 1);
        chk("flush_bit_cnt", bit_cnt0, 0);
        do_pop(8'h05, 8'hA0);

        // Flush with nothing packed does nothing
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_flush_usedw", usedw1, 0);
        chk("idle_flush_empty", empty1, 1);

        // Flush on the bit that completes the word: exactly one push
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_complete_usedw", usedw0, 1);
        chk("flush_complete_bit_cnt", bit_cnt0, 0);
        do_pop(8'hFF, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Five words with no reads: fifth is dropped
        send_byte(8'h81);
        send_byte(8'h42);
        send_byte(8'h24);
        send_byte(8'h18);
        send_byte(8'h5A);
        chk("ovf_full", full0, 1);
        chk("ovf_usedw", usedw0, 4);
        chk("ovf_flag", overflow0, 1);
        chk("ovf_bit_cnt", bit_cnt0, 0);
        do_pop(8'h81, 8'h81);
        do_pop(8'h42, 8'h42);
        do_pop(8'h24, 8'h24);
        do_pop(8'h18, 8'h18);
        chk("ovf_drain_empty", empty0, 1);
        chk("ovf_sticky", overflow0, 1);

        // Push completing while full coincides with a pop: both succeed
        do_reset();
        chk("rst2_overflow", overflow0, 0);
        send_byte(8'h81);
        send_byte(8'h42);
        send_byte(8'h24);
        send_byte(8'h18);
        chk("pp_full_before", full0, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'(8'h5A >> i), 1'b0, 1'b0);
        exp0.push_back(8'h81);
        exp1.push_back(8'h81);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_usedw", usedw0, 4);
        chk("pp_full", full0, 1);
        chk("pp_overflow", overflow0, 0);
        chk("pp_q", q0, 8'h81);
        do_pop(8'h42, 8'h42);
        do_pop(8'h24, 8'h24);
        do_pop(8'h18, 8'h18);
        do_pop(8'h5A, 8'h5A);
        chk("pp_empty", empty0, 1);

        // Reset mid-word, then a clean word and a pop on empty
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_bit_cnt", bit_cnt0, 5);
        do_reset();
        chk("mid_rst_bit_cnt", bit_cnt0, 0);
        chk("mid_rst_empty", empty0, 1);
        send_byte(8'hFF);
        chk("mid_usedw", usedw0, 1);
        do_pop(8'hFF, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("empty_rd_q_valid", q_valid0, 0);
        chk("empty_rd_q", q0, 8'hFF);
        chk("empty_rd_usedw", usedw0, 0);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
